io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
// - Device-side end of the CPU memory-mapped I/O port path: receives port writes, sources port reads.
// - CPU port writes push 16-bit words into a TX FIFO, drained to an external device over valid/ready.
// - External device pushes words into an RX FIFO over valid/ready; CPU port reads pop them.
// - A status word exposes FIFO levels and flags; one select bit picks data or status.
// PARAMETERS
// - DEPTH_LOG2  2   log2 of each FIFO's depth; legal range 1..3 (depth 2..8).
// PORTS
// - clk            in   1   system clock; all state updates on posedge.
// - rst            in   1   synchronous, active-high reset.
// - io_sel         in   1   0 = data register, 1 = status register.
// - io_write_en    in   1   CPU port write strobe, one cycle per write.
// - io_write_data  in   16  CPU write data.
// - io_read_en     in   1   CPU port read strobe, one cycle per read.
// - io_read_data   out  16  CPU read data; combinational.
// - dev_tx_data    out  16  head of TX FIFO.
// - dev_tx_valid   out  1   TX FIFO non-empty.
// - dev_tx_ready   in   1   device accepts dev_tx_data.
// - dev_rx_data    in   16  word from device.
// - dev_rx_valid   in   1   dev_rx_data valid.
// - dev_rx_ready   out  1   RX FIFO can accept.
// BEHAVIOUR
// - Reset: both FIFOs empty; pointers and counts 0; dev_tx_valid=0.
// - During reset: dev_rx_ready=0; io_read_data=0. Reset mid-transfer discards all FIFO contents.
// - FIFO structure:
//   - Circular buffers; pointers DEPTH_LOG2 bits, wrapping naturally.
//   - Counts DEPTH_LOG2+1 bits, range 0..DEPTH.
// - TX push (io_write_en & io_sel==0):
//   - Accepted if tx_count<DEPTH, or if a TX pop occurs in the same cycle.
//   - Otherwise the word is dropped (overflow).
// - TX pop: dev_tx_valid & dev_tx_ready at posedge.
//   - dev_tx_data/dev_tx_valid come straight from the FIFO head/count (0-cycle latency).
//   - dev_tx_data is don't-care when invalid.
// - RX push: dev_rx_valid & dev_rx_ready.
//   - dev_rx_ready = !rst & (rx_count<DEPTH); no push-through when full.
// - RX pop (io_read_en & io_sel==0):
//   - If rx_count>0: io_read_data = RX head this cycle; pop at posedge.
//   - If empty: io_read_data=0x0000, no pop (underflow).
// - Status read (io_read_en & io_sel==1): io_read_data =
//   - [0]    rx_empty
//   - [1]    rx_full
//   - [2]    tx_empty
//   - [3]    tx_full
//   - [7:4]  rx_count, zero-extended
//   - [11:8] tx_count, zero-extended
//   - [12]   ovf
//   - [13]   unf
//   - [15:14] 0
// - io_read_data = 0x0000 whenever io_read_en=0.
// - Write with io_sel==1: no FIFO effect (see CONFIGURATION).
// - Simultaneous events:
//   - io_write_en, io_read_en and both device handshakes in one cycle are all honoured independently.
//   - Push+pop on the same FIFO leaves its count unchanged.
// CONFIGURATION
// - IO_STICKY_ERR_EN defined:
//   - ovf set on a dropped TX push; unf set on a data read of an empty RX FIFO.
//   - Both flags clear on reset or on a status write with io_write_data[0]=1.
//   - Set and clear in the same cycle -> set wins.
// - IO_STICKY_ERR_EN undefined: ovf/unf read 0; status writes fully ignored.
// TESTING
// - Reset, then read status -> 0x0005; dev_tx_valid=0; dev_rx_ready=1 one cycle after rst falls.
// - Write 0x1111,0x2222 with dev_tx_ready=0, then ready=1 -> 0x1111 then 0x2222 on consecutive cycles; valid falls after.
// - Depth 4, ready=0, write 5 words -> status tx_count=4, tx_full=1; ovf=1 only with IO_STICKY_ERR_EN.
// - Device pushes 0xA5A5, 0x5A5A; CPU reads data twice -> 0xA5A5, 0x5A5A.
//   - Third read -> 0x0000, rx_empty=1, unf=1 only with macro.
// - TX full + write + dev_tx_ready in same cycle -> write accepted, tx_count stays 4, no ovf.
// - RX full, dev_rx_valid held -> dev_rx_ready=0; CPU pop -> ready=1 next cycle, held word enters.

Source files
------------

// File: rtl/io_port_responder.sv
// Device-side I/O port responder: CPU writes feed a TX FIFO to the device, device words fill an RX FIFO read by the CPU.
// Optional feature macro IO_STICKY_ERR_EN enables sticky overflow/underflow flags in the status word.
module io_port_responder #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sel,
    input  logic        io_write_en,
    input  logic [15:0] io_write_data,
    input  logic        io_read_en,
    output logic [15:0] io_read_data,
    output logic [15:0] dev_tx_data,
    output logic        dev_tx_valid,
    input  logic        dev_tx_ready,
    input  logic [15:0] dev_rx_data,
    input  logic        dev_rx_valid,
    output logic        dev_rx_ready
);

    // Handshakes: a word moves on a posedge where valid and ready are both high;
    // valid never waits on ready, and data is held while valid is high and ready low.

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [15:0]           tx_mem_q [DEPTH];
    logic [15:0]           rx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0]         tx_count_q, tx_count_d, rx_count_q, rx_count_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ovf, unf;

    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == DEPTH_C);
    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == DEPTH_C);

    assign dev_tx_valid = !tx_empty;
    assign dev_tx_data  = tx_mem_q[tx_rd_ptr_q];
    assign dev_rx_ready = !rst && !rx_full;

    // A full TX FIFO still takes a write when the head leaves in the same cycle.
    assign tx_pop  = dev_tx_valid && dev_tx_ready;
    assign tx_push = io_write_en && !io_sel && (!tx_full || tx_pop);
    assign rx_push = dev_rx_valid && dev_rx_ready;
    assign rx_pop  = io_read_en && !io_sel && !rx_empty;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
        if (tx_push && !tx_pop) tx_count_d = tx_count_q + 1'b1;
        if (!tx_push && tx_pop) tx_count_d = tx_count_q - 1'b1;
        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
        if (rx_push && !rx_pop) rx_count_d = rx_count_q + 1'b1;
        if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // Storage needs no reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && tx_push) tx_mem_q[tx_wr_ptr_q] <= io_write_data;
        if (!rst && rx_push) rx_mem_q[rx_wr_ptr_q] <= dev_rx_data;
    end

`ifdef IO_STICKY_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic err_clr;

    assign err_clr = io_write_en && io_sel && io_write_data[0];

    always_comb begin
        ovf_d = err_clr ? 1'b0 : ovf_q;
        unf_d = err_clr ? 1'b0 : unf_q;
        if (io_write_en && !io_sel && !tx_push) ovf_d = 1'b1;
        if (io_read_en && !io_sel && rx_empty)  unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    logic [15:0] status;
    assign status = {2'b00, unf, ovf, 4'(tx_count_q), 4'(rx_count_q),
                     tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        io_read_data = 16'h0000;
        if (!rst && io_read_en) begin
            if (io_sel)         io_read_data = status;
            else if (!rx_empty) io_read_data = rx_mem_q[rx_rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: expected CPU reads and device TX words are queued
// by the stimulus and checked by a separate monitor at the falling edge.
module tb_io_port_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_sel = 1'b0;
    logic        io_write_en = 1'b0;
    logic [15:0] io_write_data = '0;
    logic        io_read_en = 1'b0;
    logic [15:0] io_read_data;
    logic [15:0] dev_tx_data;
    logic        dev_tx_valid;
    logic        dev_tx_ready = 1'b0;
    logic [15:0] dev_rx_data = '0;
    logic        dev_rx_valid = 1'b0;
    logic        dev_rx_ready;

`ifdef IO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [15:0] OVF_BIT = STICKY ? 16'h1000 : 16'h0000;
    localparam logic [15:0] UNF_BIT = STICKY ? 16'h2000 : 16'h0000;

    int total = 0;
    int bad   = 0;
    logic [15:0] rd_exp_q[$];
    logic [15:0] tx_exp_q[$];

    io_port_responder #(.DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst),
        .io_sel(io_sel), .io_write_en(io_write_en), .io_write_data(io_write_data),
        .io_read_en(io_read_en), .io_read_data(io_read_data),
        .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready),
        .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (io_read_en) begin
                if (rd_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL io_read_unexpected: got %h expected nothing", io_read_data);
                end else check("io_read", io_read_data, rd_exp_q.pop_front());
            end
            if (dev_tx_valid && dev_tx_ready) begin
                if (tx_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dev_tx_unexpected: got %h expected nothing", dev_tx_data);
                end else check("dev_tx", dev_tx_data, tx_exp_q.pop_front());
            end
        end
    end

    // driver tasks: each starts and ends 1 time unit after a posedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic sel, input logic [15:0] data);
        io_write_en = 1'b1; io_sel = sel; io_write_data = data;
        step();
        io_write_en = 1'b0; io_sel = 1'b0;
    endtask

    task automatic cpu_read(input logic sel, input logic [15:0] exp);
        io_read_en = 1'b1; io_sel = sel;
        rd_exp_q.push_back(exp);
        step();
        io_read_en = 1'b0; io_sel = 1'b0;
    endtask

    task automatic dev_push(input logic [15:0] data);
        dev_rx_valid = 1'b1; dev_rx_data = data;
        step();
        dev_rx_valid = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) step();
        check("rst_tx_valid", {15'd0, dev_tx_valid}, 16'h0000);
        check("rst_rx_ready", {15'd0, dev_rx_ready}, 16'h0000);
        io_read_en = 1'b1; io_sel = 1'b1;
        #1 check("rst_read_data", io_read_data, 16'h0000);
        io_read_en = 1'b0; io_sel = 1'b0;
        rst = 1'b0;
        step();
        check("rx_ready_after_rst", {15'd0, dev_rx_ready}, 16'h0001);
        cpu_read(1'b1, 16'h0005);

        // two words held then drained on consecutive cycles
        cpu_write(1'b0, 16'h1111);
        cpu_write(1'b0, 16'h2222);
        check("tx_valid_held", {15'd0, dev_tx_valid}, 16'h0001);
        check("tx_head_held", dev_tx_data, 16'h1111);
        tx_exp_q.push_back(16'h1111);
        tx_exp_q.push_back(16'h2222);
        dev_tx_ready = 1'b1;
        step();
        step();
        dev_tx_ready = 1'b0;
        check("tx_valid_drained", {15'd0, dev_tx_valid}, 16'h0000);

        // overflow: 5 writes into depth 4
        for (int i = 1; i <= 5; i++) cpu_write(1'b0, 16'(i * 16'h0101));
        cpu_read(1'b1, 16'h0409 | OVF_BIT);
        cpu_write(1'b1, 16'h0001);
        cpu_read(1'b1, 16'h0409);

        // full TX with write and pop in the same cycle
        io_write_en = 1'b1; io_sel = 1'b0; io_write_data = 16'h0606;
        dev_tx_ready = 1'b1;
        tx_exp_q.push_back(16'h0101);
        step();
        io_write_en = 1'b0; dev_tx_ready = 1'b0;
        cpu_read(1'b1, 16'h0409);
        tx_exp_q.push_back(16'h0202);
        tx_exp_q.push_back(16'h0303);
        tx_exp_q.push_back(16'h0404);
        tx_exp_q.push_back(16'h0606);
        dev_tx_ready = 1'b1;
        repeat (4) step();
        dev_tx_ready = 1'b0;
        check("tx_empty_after_drain", {15'd0, dev_tx_valid}, 16'h0000);

        // RX path and underflow
        dev_push(16'hA5A5);
        dev_push(16'h5A5A);
        cpu_read(1'b0, 16'hA5A5);
        cpu_read(1'b0, 16'h5A5A);
        cpu_read(1'b0, 16'h0000);
        cpu_read(1'b1, 16'h0005 | UNF_BIT);
        cpu_write(1'b1, 16'h0001);
        cpu_read(1'b1, 16'h0005);

        // RX full with device word held, then a CPU pop frees a slot
        for (int i = 1; i <= 4; i++) dev_push(16'h0C00 | 16'(i));
        dev_rx_valid = 1'b1; dev_rx_data = 16'h0C05;
        #1 check("rx_ready_full", {15'd0, dev_rx_ready}, 16'h0000);
        cpu_read(1'b1, 16'h0046);
        cpu_read(1'b0, 16'h0C01);
        check("rx_ready_after_pop", {15'd0, dev_rx_ready}, 16'h0001);
        step();
        dev_rx_valid = 1'b0;
        cpu_read(1'b1, 16'h0046);
        for (int i = 2; i <= 5; i++) cpu_read(1'b0, 16'h0C00 | 16'(i));

        // every event in one cycle
        dev_push(16'h7777);
        dev_rx_valid = 1'b1; dev_rx_data = 16'h8888;
        io_read_en = 1'b1; rd_exp_q.push_back(16'h7777);
        io_write_en = 1'b1; io_write_data = 16'h9999; io_sel = 1'b0;
        step();
        dev_rx_valid = 1'b0; io_read_en = 1'b0; io_write_en = 1'b0;
        cpu_read(1'b1, 16'h0110);
        cpu_read(1'b0, 16'h8888);
        tx_exp_q.push_back(16'h9999);
        dev_tx_ready = 1'b1;
        step();
        dev_tx_ready = 1'b0;
        cpu_read(1'b1, 16'h0005);

        // reset mid-transfer discards contents and sticky flags
        cpu_write(1'b0, 16'hDEAD);
        dev_push(16'hBEEF);
        cpu_read(1'b0, 16'hBEEF);
        cpu_read(1'b0, 16'h0000);
        cpu_write(1'b0, 16'hCAFE);
        dev_push(16'hF00D);
        rst = 1'b1;
        step();
        check("rst_mid_rx_ready", {15'd0, dev_rx_ready}, 16'h0000);
        rst = 1'b0;
        step();
        check("rst_mid_tx_valid", {15'd0, dev_tx_valid}, 16'h0000);
        cpu_read(1'b1, 16'h0005);
        cpu_read(1'b0, 16'h0000);
        cpu_write(1'b1, 16'h0001);

        // drain with a bounded wait
        for (int i = 0; i < 20 && (rd_exp_q.size() != 0 || tx_exp_q.size() != 0); i++) step();
        if (rd_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", rd_exp_q.size(), tx_exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
